// File: rtl/servo_pwm_pkg.sv
// Shared definitions for the servo feedback PWM capture block: register map,
// status/control bit positions and the measurement state encoding.
package servo_pwm_pkg;

  localparam logic [1:0] ADDR_WIDTH  = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int STAT_VALID    = 0;
  localparam int STAT_TIMEOUT  = 1;
  localparam int STAT_OVERFLOW = 2;
  localparam int STAT_LEVEL    = 3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } capture_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Pin conditioning for the PWM feedback input: 2-flop synchronizer, optional
// glitch filter (FILTER_LEN > 0, selected by SERVO_PWM_CAPTURE_FILTER_EN in the top) and edge pulses.
module pwm_in_sync #(
  parameter int FILTER_LEN = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync0;
  logic sync1;
  logic filt;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync0 <= pwm_in;
      sync1 <= sync0;
      prev  <= filt;
    end
  end

  if (FILTER_LEN > 0) begin : g_filter
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    logic [FW-1:0] run_cnt;

    // The filtered level follows the synced pin only after FILTER_LEN
    // consecutive samples disagree with it; any agreement restarts the run.
    always_ff @(posedge clk) begin
      if (reset) begin
        filt    <= 1'b0;
        run_cnt <= '0;
      end else if (sync1 == filt) begin
        run_cnt <= '0;
      end else if (run_cnt == FW'(FILTER_LEN - 1)) begin
        filt    <= sync1;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end else begin : g_bypass
    assign filt = sync1;
  end

  assign level = sync1;
  assign rise  = filt & ~prev;
  assign fall  = ~filt & prev;

endmodule

// File: rtl/servo_pwm_capture.sv
// Avalon-MM servo feedback PWM capture: measures high time and period of pwm_in.
// Define SERVO_PWM_CAPTURE_FILTER_EN to insert a FILTER_LEN-sample glitch filter.
module servo_pwm_capture
  import servo_pwm_pkg::*;
#(
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int FILTER_LEN     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  input  logic        pwm_in,
  output logic        irq
);

`ifdef SERVO_PWM_CAPTURE_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [31:0]      TIMEOUT_VAL = 32'(TIMEOUT_CYCLES);

  logic level;
  logic rise;
  logic fall;

  capture_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] pend_w;
  logic [CNT_W-1:0] width_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] period_shadow;

  logic valid;
  logic timeout;
  logic overflow;
  logic enable;
  logic irq_en;

  logic        publish;
  logic        hit_timeout;
  logic        hit_overflow;
  logic [2:0]  status_clr;
  logic [31:0] read_mux;
  logic        unused_wdata;

  pwm_in_sync #(
    .FILTER_LEN(FILTER_EN ? FILTER_LEN : 0)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .pwm_in(pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // Hardware flag events, shared by the measurement FSM and the status
  // register so that a same-cycle software clear can lose to them.
  always_comb begin
    cnt_inc      = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    publish      = 1'b0;
    hit_timeout  = 1'b0;
    hit_overflow = 1'b0;
    if (enable) begin
      case (state)
        HIGH: begin
          hit_timeout  = !fall && (32'(cnt) == TIMEOUT_VAL);
          hit_overflow = !hit_timeout && (cnt == CNT_MAX);
        end
        LOW: begin
          publish      = rise;
          hit_timeout  = !rise && (32'(cnt) == TIMEOUT_VAL);
          hit_overflow = !rise && !hit_timeout && (cnt == CNT_MAX);
        end
        default: ;
      endcase
    end
  end

  // Measurement FSM: a period runs rise-to-rise, the width is parked in pend_w
  // at the falling edge and both are published together at the next rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_w     <= '0;
      width_reg  <= '0;
      period_reg <= '0;
    end else if (!enable) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state <= HIGH;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        HIGH: begin
          if (fall) begin
            pend_w <= cnt;
            state  <= LOW;
            cnt    <= cnt_inc;
          end else if (hit_timeout) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        LOW: begin
          if (publish) begin
            width_reg  <= pend_w;
            period_reg <= cnt;
            state      <= HIGH;
            cnt        <= CNT_W'(1);
          end else if (hit_timeout) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    status_clr = '0;
    if (avs_write && (avs_address == ADDR_STATUS)) begin
      status_clr[STAT_VALID]    = avs_writedata[STAT_VALID];
      status_clr[STAT_TIMEOUT]  = avs_writedata[STAT_TIMEOUT];
      status_clr[STAT_OVERFLOW] = avs_writedata[STAT_OVERFLOW];
    end
  end

  always_comb begin
    read_mux = '0;
    case (avs_address)
      ADDR_WIDTH:  read_mux = 32'(width_reg);
      ADDR_PERIOD: read_mux = 32'(period_shadow);
      ADDR_STATUS: begin
        read_mux[STAT_VALID]    = valid;
        read_mux[STAT_TIMEOUT]  = timeout;
        read_mux[STAT_OVERFLOW] = overflow;
        read_mux[STAT_LEVEL]    = level;
      end
      default: begin
        read_mux[CTRL_ENABLE] = enable;
        read_mux[CTRL_IRQ_EN] = irq_en;
      end
    endcase
  end

  // Register file. Reading WIDTH captures the PERIOD that belongs with it, so
  // a WIDTH/PERIOD read pair is never split across an update.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid         <= 1'b0;
      timeout       <= 1'b0;
      overflow      <= 1'b0;
      enable        <= 1'b0;
      irq_en        <= 1'b0;
      period_shadow <= '0;
      avs_readdata  <= '0;
    end else begin
      valid    <= (valid    & ~status_clr[STAT_VALID])    | publish;
      timeout  <= (timeout  & ~status_clr[STAT_TIMEOUT])  | hit_timeout;
      overflow <= (overflow & ~status_clr[STAT_OVERFLOW]) | hit_overflow;
      if (avs_write && (avs_address == ADDR_CTRL)) begin
        enable <= avs_writedata[CTRL_ENABLE];
        irq_en <= avs_writedata[CTRL_IRQ_EN];
      end
      if (avs_read) begin
        avs_readdata <= read_mux;
        if (avs_address == ADDR_WIDTH) begin
          period_shadow <= period_reg;
        end
      end
    end
  end

  assign irq          = valid & irq_en;
  assign unused_wdata = ^avs_writedata[31:3];

endmodule

// File: doc/servo_pwm_capture.md
Name: servo_pwm_capture

Overview:
Measures pulse width and period of a servo feedback PWM signal arriving on an FPGA pin. The signal is the response line paired with each servo PWM output. The block sits in the Computer_System as an Avalon-MM slave, one instance per feedback input. The HPS reads the latest measurement, status flags and live pin level through four 32-bit registers.

Parameters:
CNT_W, 24, width of the width/period counters in clk cycles (24 bits covers 335 ms at 50 MHz).
TIMEOUT_CYCLES, 2500000, cycles without a rising edge before a timeout is declared (50 ms at 50 MHz).
FILTER_LEN, 4, number of consecutive equal samples the glitch filter requires (used only with the optional feature).

Ports:
clk  in  1  system clock, 50 MHz, from the system PLL.
reset  in  1  synchronous reset, active-high.
avs_address  in  2  register word address.
avs_read  in  1  Avalon read strobe.
avs_write  in  1  Avalon write strobe.
avs_writedata  in  32  write data.
avs_readdata  out  32  registered read data.
pwm_in  in  1  asynchronous PWM feedback pin.
irq  out  1  level interrupt, asserted when (status.valid & ctrl.irq_en).

Behaviour:
- Register map:
  - 0 WIDTH: high time in cycles, CNT_W bits, zero-extended. Reading it snapshots PERIOD into a shadow register.
  - 1 PERIOD: returns the shadow value.
  - 2 STATUS: bit0 valid, bit1 timeout, bit2 overflow, bit3 live synced level. Bits 0-2 are sticky; writing 1 to a bit clears it.
  - 3 CTRL: bit0 enable, bit1 irq_en. Read/write.
- Reset values: all outputs 0, all registers 0, state IDLE.
- Read latency is exactly 1 cycle. avs_readdata holds its value between reads. No waitrequest.
- Input path: 2-flop synchronizer, then an edge-detect flop. An edge on the pin becomes visible 3 cycles later. The delay is constant, so measured values are unaffected.
- Counter cnt:
  - Loads 1 on each detected rising edge, then increments by 1 per cycle.
  - Saturates at 2^CNT_W-1. On saturation the overflow flag is set.
- State machine:
  - IDLE: wait for enable=1 and a rising edge, then go to HIGH with cnt=1.
  - HIGH: on a falling edge, latch pend_w<=cnt and go to LOW.
  - LOW: on a rising edge, WIDTH<=pend_w, PERIOD<=cnt, set valid, cnt<=1, go to HIGH.
  - The first complete period after IDLE is published. There is no discard cycle.
- Timeout: in HIGH or LOW, when cnt reaches TIMEOUT_CYCLES, set timeout, go to IDLE and keep WIDTH/PERIOD. The valid bit is not cleared. Software reads bit3 to tell 0% from 100% duty.
- enable=0: state forced to IDLE and cnt to 0 on the next cycle; registers are kept. Clearing enable mid-pulse abandons the measurement.
- Simultaneous events:
  - A hardware flag set and a W1C clear in the same cycle: the set wins.
  - A WIDTH register update and a read of address 0 in the same cycle: the read returns the old WIDTH, and the shadow takes the old PERIOD, so the pair stays consistent.
- A write to address 0 or 1 is ignored.
- reset asserted mid-measurement: everything returns to reset values on the next clk edge.

Optional Feature:
SERVO_PWM_CAPTURE_FILTER_EN
- Defined: a glitch filter follows the synchronizer. The filtered level changes only after FILTER_LEN consecutive equal samples. This adds FILTER_LEN cycles of constant latency, and pulses shorter than FILTER_LEN cycles are rejected.
- Undefined: the filter is absent, and any pulse of 1 cycle or longer is measured.

Decomposition:
- Shared package servo_pwm_pkg holds:
  - register address constants ADDR_WIDTH=0, ADDR_PERIOD=1, ADDR_STATUS=2, ADDR_CTRL=3;
  - status bit index constants;
  - a state enum typedef with IDLE, HIGH, LOW.
- One sub-module, pwm_in_sync: synchronizer, optional filter, and rise/fall pulse outputs.

Test Plan:
- Enable, then drive 1.5 ms high / 20 ms period at 50 MHz → WIDTH=75000, PERIOD=1000000, valid=1, irq=1 if irq_en=1.
- Change to 1.0 ms / 20 ms mid-stream → the next update gives WIDTH=50000, PERIOD=1000000; no intermediate corrupt value.
- Hold pin low for 2500000 cycles after a pulse → timeout=1, state IDLE, STATUS bit3=0. Hold high instead → bit3=1.
- Write STATUS=0x1 in the same cycle a new period completes → valid remains 1.
- Read WIDTH in the cycle of an update, then read PERIOD → the old width is paired with the old period. The next pair read is the new width/new period.
- With the filter enabled and FILTER_LEN=4, inject 2-cycle glitches during the low phase → WIDTH/PERIOD unchanged from the clean values. Without the filter, a 2-cycle glitch produces PERIOD equal to the glitch spacing.
